// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: sequences a FIR datapath from a sample memory, tracks filter
// latency with a valid pipe, presents results on valid/ready and flushes the
// filter with zeros at the end of a run.
// Optional macro FIR_CTRL_CNT_EN adds result_cnt (accepted output transfers).
module fir_stream_ctrl #(
  parameter int unsigned N     = 16,
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned LAT   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  input  logic [AW:0]   num_samples,
  output logic [AW-1:0] mem_addr,
  input  logic [N-1:0]  mem_data,
  output logic          fir_en,
  output logic [N-1:0]  fir_data_in,
  input  logic [N-1:0]  fir_data_out,
  output logic [N-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
`ifdef FIR_CTRL_CNT_EN
  ,
  output logic [15:0]   result_cnt
`endif
);

  localparam int unsigned   CW        = AW + 1;
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_q;
  state_t          state_nxt;
  logic            loop_q;
  logic [CW-1:0]   total_q;
  logic [CW-1:0]   sent_q;
  logic [CW-1:0]   sent_inc;
  logic [LAT-1:0]  vpipe_q;
  logic            adv;
  logic            start_acc;

  // Handshake and bookkeeping helpers
  assign adv       = !out_valid || out_ready;
  assign start_acc = (state_q == IDLE) && start;
  assign sent_inc  = sent_q + CW'(1);
  assign out_valid = vpipe_q[LAT-1];
  assign out_data  = fir_data_out;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state decode and filter feed (enable is combinational so stalls act at once)
  always_comb begin
    state_nxt   = state_q;
    fir_en      = 1'b0;
    fir_data_in = '0;
    case (state_q)
      IDLE:  if (start) state_nxt = PRIME;
      PRIME: state_nxt = RUN;
      RUN: begin
        fir_en      = adv;
        fir_data_in = mem_data;
        if (stop || (adv && !loop_q && (sent_inc == total_q))) state_nxt = FLUSH;
      end
      FLUSH: begin
        fir_en = adv;
        if (vpipe_q == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Run configuration, read address and sample count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loop_q   <= 1'b0;
      total_q  <= '0;
      sent_q   <= '0;
      mem_addr <= '0;
    end else if (start_acc) begin
      loop_q   <= loop_en;
      total_q  <= (num_samples == '0) ? DEPTH_CNT : num_samples;
      sent_q   <= '0;
      mem_addr <= '0;
    end else if ((state_q == RUN) && fir_en) begin
      mem_addr <= (mem_addr == ADDR_LAST) ? '0 : mem_addr + AW'(1);
      sent_q   <= (sent_q == CNT_MAX) ? sent_q : sent_inc;
    end
  end

  // Valid pipe mirrors filter latency; ones enter while feeding samples, zeros while flushing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vpipe_q <= '0;
    end else if (fir_en) begin
      for (int unsigned i = 1; i < LAT; i++) vpipe_q[i] <= vpipe_q[i-1];
      vpipe_q[0] <= (state_q == RUN);
    end
  end

  // Registered status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
    end
  end

`ifdef FIR_CTRL_CNT_EN
  logic xfer;
  assign xfer = out_valid && out_ready;

  // Accepted output transfer counter, cleared on each accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         result_cnt <= '0;
    else if (start_acc) result_cnt <= '0;
    else if (xfer)      result_cnt <= result_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Bench for fir_stream_ctrl: async-read sample memory with mem[i]=i+1, a
// 2-stage enable-gated delay as the filter, and a sequence-level model.
module tb_fir_stream_ctrl;

  localparam int unsigned N     = 16;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned LAT   = 2;

  logic          clk;
  logic          reset;
  logic          start;
  logic          stop;
  logic          loop_en;
  logic [AW:0]   num_samples;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_data;
  logic          fir_en;
  logic [N-1:0]  fir_data_in;
  logic [N-1:0]  fir_data_out;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
`ifdef FIR_CTRL_CNT_EN
  logic [15:0]   result_cnt;
`endif

  fir_stream_ctrl #(.N(N), .AW(AW), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .loop_en      (loop_en),
    .num_samples  (num_samples),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .fir_en       (fir_en),
    .fir_data_in  (fir_data_in),
    .fir_data_out (fir_data_out),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done)
`ifdef FIR_CTRL_CNT_EN
    ,
    .result_cnt   (result_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample memory, readable in the cycle after mem_addr is registered
  logic [N-1:0] mem [DEPTH];
  initial for (int i = 0; i < int'(DEPTH); i++) mem[i] = N'(i + 1);
  assign mem_data = mem[mem_addr];

  // Filter stand-in: 2-stage delay that advances only on fir_en
  logic [N-1:0] f1, f2;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f1 <= '0;
      f2 <= '0;
    end else if (fir_en) begin
      f1 <= fir_data_in;
      f2 <= f1;
    end
  end
  assign fir_data_out = f2;

  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Run description written by the driver, consumed by the model
  int   run_id;
  int   cfg_total;
  logic cfg_oneshot;
  logic cfg_feed;

  // Model state (written by the checker only)
  int            seen_id;
  int            k;
  int            results;
  int            done_cnt;
  logic          feeding;
  logic          saw_wrap;
  logic          prev_done;
  int            last_addr;
  logic [N-1:0]  exp_q[$];
  logic [N-1:0]  out_log[$];

  // Sequence model: each consumed sample is mem[k mod DEPTH]; results come out in consume order
  initial begin
    seen_id = 0; k = 0; results = 0; done_cnt = 0; feeding = 1'b0;
    saw_wrap = 1'b0; prev_done = 1'b0; last_addr = -1;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        prev_done = 1'b0;
      end else if (run_id != seen_id) begin
        seen_id = run_id; k = 0; results = 0; feeding = cfg_feed;
        saw_wrap = 1'b0; last_addr = -1;
        exp_q.delete(); out_log.delete();
        prev_done = done;
      end else begin
        if (out_valid && !out_ready) chk("stall_fir_en", 32'(fir_en), 32'd0);
        if (fir_en) begin
          if (feeding) begin
            chk("consume_addr", 32'(mem_addr), 32'(k % int'(DEPTH)));
            chk("consume_data", 32'(fir_data_in), 32'(k % int'(DEPTH) + 1));
            if (last_addr == int'(DEPTH) - 1 && mem_addr == '0) saw_wrap = 1'b1;
            last_addr = int'(mem_addr);
            exp_q.push_back(N'(k % int'(DEPTH) + 1));
            k++;
            if (cfg_oneshot && k == cfg_total) feeding = 1'b0;
          end else begin
            chk("flush_zero", 32'(fir_data_in), 32'd0);
          end
        end
        if (stop && feeding) feeding = 1'b0;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'(out_valid), 32'd0);
          end else begin
            chk("out_data", 32'(out_data), 32'(exp_q[0]));
            if (out_ready) begin
              out_log.push_back(out_data);
              void'(exp_q.pop_front());
              results++;
            end
          end
        end
        if (done) begin
          done_cnt++;
          chk("done_single", 32'(prev_done), 32'd0);
          chk("done_drained", 32'(exp_q.size()), 32'd0);
          chk("done_results", 32'(results), 32'(k));
          if (cfg_oneshot) chk("done_total", 32'(k), 32'(cfg_total));
        end
        prev_done = done;
      end
    end
  end

  task automatic start_run(input logic lp, input logic [AW:0] ns, input logic with_stop);
    @(negedge clk);
    start = 1'b1; loop_en = lp; num_samples = ns; stop = with_stop;
    cfg_oneshot = !lp; cfg_total = (ns == '0) ? int'(DEPTH) : int'(ns); cfg_feed = 1'b1;
    run_id++;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; num_samples = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    for (n = 0; n < budget && busy; n++) @(negedge clk);
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_out(input logic [N-1:0] val);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (out_valid && out_data == val) found = 1'b1;
    end
    chk("wait_out", 32'(found), 32'd1);
  endtask

  task automatic check_log(input string name, input int idx, input int exp);
    chk(name, 32'(out_log[idx]), 32'(exp));
  endtask

  int dc;
  logic [AW-1:0] addr_hold;

  initial begin
    checks = 0; errors = 0; run_id = 0; cfg_total = 0; cfg_oneshot = 1'b0; cfg_feed = 1'b0;
    reset = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; num_samples = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_fir_en", 32'(fir_en), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy_done", 32'({busy, done}), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // One-shot of 5 with an ignored start in the middle
    start_run(1'b0, 6'd5, 1'b0);
    chk("prime_fir_en", 32'(fir_en), 32'd0);
    repeat (2) @(negedge clk);
    start = 1'b1; loop_en = 1'b1; num_samples = 6'd2;
    @(negedge clk);
    start = 1'b0; loop_en = 1'b0; num_samples = '0;
    wait_idle(200);
    chk("os_results", 32'(results), 32'd5);
    for (int i = 0; i < 5; i++) check_log("os_seq", i, i + 1);
    chk("os_addr_end", 32'(mem_addr), 32'd5);
    chk("os_done_cnt", 32'(done_cnt), 32'd1);
`ifdef FIR_CTRL_CNT_EN
    chk("os_result_cnt", 32'(result_cnt), 32'd5);
`endif

    // Backpressure while result 2 is presented
    start_run(1'b0, 6'd5, 1'b0);
    wait_out(N'(2));
    out_ready = 1'b0;
    repeat (3) begin
      #2;
      chk("bp_data", 32'(out_data), 32'd2);
      chk("bp_fir_en", 32'(fir_en), 32'd0);
      chk("bp_addr", 32'(mem_addr), 32'd3);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_idle(200);
    chk("bp_results", 32'(results), 32'd5);
    for (int i = 0; i < 5; i++) check_log("bp_seq", i, i + 1);

    // Looping with wrap, stopped on the 40th consume
    start_run(1'b1, 6'd0, 1'b0);
    for (dc = 0; dc < 200 && k != 39; dc++) @(negedge clk);
    chk("loop_reach_39", 32'(k), 32'd39);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle(200);
    chk("loop_consumes", 32'(k), 32'd40);
    chk("loop_results", 32'(results), 32'd40);
    chk("loop_wrap", 32'(saw_wrap), 32'd1);
    check_log("loop_31", 31, 32);
    check_log("loop_32", 32, 1);
    check_log("loop_39", 39, 8);
    chk("loop_done_cnt", 32'(done_cnt), 32'd3);

    // num_samples=0 one-shot, with a coincident stop that start overrides
    start_run(1'b0, 6'd0, 1'b1);
    wait_idle(200);
    chk("full_results", 32'(results), 32'd32);
    check_log("full_first", 0, 1);
    check_log("full_last", 31, 32);

    // Reset mid-run while result 3 is presented
    start_run(1'b0, 6'd5, 1'b0);
    wait_out(N'(3));
    reset = 1'b0; cfg_feed = 1'b0; run_id++;
    #1;
    chk("mrst_addr", 32'(mem_addr), 32'd0);
    chk("mrst_fir", 32'({fir_en, fir_data_in}), 32'd0);
    chk("mrst_out", 32'({out_valid, out_data}), 32'd0);
    chk("mrst_status", 32'({busy, done}), 32'd0);
`ifdef FIR_CTRL_CNT_EN
    chk("mrst_result_cnt", 32'(result_cnt), 32'd0);
`endif
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_no_done", 32'(done_cnt), 32'd4);
    start_run(1'b0, 6'd5, 1'b0);
    wait_idle(200);
    chk("mrst_rerun", 32'(results), 32'd5);
    for (int i = 0; i < 5; i++) check_log("mrst_seq", i, i + 1);

    // Stop pulsed in IDLE is ignored
    addr_hold = mem_addr;
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_stop_busy", 32'(busy), 32'd0);
    chk("idle_stop_addr", 32'(mem_addr), 32'(addr_hold));
    chk("idle_stop_done", 32'(done_cnt), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
